// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared FSM states, phase counter width and default latch timing
package latch_bank_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, READ, DONE} state_t;
  localparam int PHASE_W = 8;
  localparam int DEF_SETUP = 1;
  localparam int DEF_PULSE = 2;
  localparam int DEF_HOLD = 1;
endpackage

// File: rtl/latch_bank_writer_phase_timer.sv
// phase_timer: loadable down-counter, tc flags the last cycle of a phase
module phase_timer
  import latch_bank_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PHASE_W-1:0] val,
  output logic               tc
);
  logic [PHASE_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? val : (cnt != '0) ? cnt - PHASE_W'(1) : cnt;
  assign tc = cnt == PHASE_W'(1);
endmodule

// File: rtl/latch_bank_writer.sv
// latch_bank_writer: writes a word into an external gated-latch bank and verifies the readback
// Optional single retry on mismatch when LATCH_BANK_WRITER_RETRY_EN is defined.
module latch_bank_writer
  import latch_bank_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = DEF_SETUP,
  parameter int PULSE_CYC = DEF_PULSE,
  parameter int HOLD_CYC  = DEF_HOLD
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data,
  output logic             Busy,
  output logic             Done,
  output logic             Mismatch,
  output logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] LatchD,
  output logic             LatchEn,
`ifdef LATCH_BANK_WRITER_RETRY_EN
  output logic             Retried,
`endif
  input  logic [WIDTH-1:0] LatchQ
);
  state_t state, next;
  logic [WIDTH-1:0] word;
  logic [PHASE_W-1:0] load_val;
  logic load, tc, accept, again;
  phase_timer u_timer (.clk(Clk), .rst(Reset), .load(load), .val(load_val), .tc(tc));
  assign accept = (state == IDLE) && Start && !Done;
`ifdef LATCH_BANK_WRITER_RETRY_EN
  logic tried;
  assign again = (LatchQ != word) && !tried;
  always_ff @(posedge Clk) begin
    tried   <= Reset ? 1'b0 : accept ? 1'b0 : (state == READ && again) ? 1'b1 : tried;
    Retried <= Reset ? 1'b0 : accept ? 1'b0 : (state == DONE) ? tried : Retried;
  end
`else
  assign again = 1'b0;
`endif
  always_comb begin
    next = state;
    load = 1'b0;
    load_val = PHASE_W'(SETUP_CYC);
    case (state)
      IDLE: if (accept) begin next = SETUP; load = 1'b1; end
      SETUP: if (tc) begin next = PULSE; load = 1'b1; load_val = PHASE_W'(PULSE_CYC); end
      PULSE: if (tc) begin next = HOLD; load = 1'b1; load_val = PHASE_W'(HOLD_CYC); end
      HOLD: if (tc) next = READ;
      READ: begin next = again ? SETUP : DONE; load = again; end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge Clk) state <= Reset ? IDLE : next;
  // Outputs are decoded from the current state one edge late, so every phase keeps its exact length.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      word <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
      Mismatch <= 1'b0;
      ReadData <= '0;
      LatchD <= '0;
      LatchEn <= 1'b0;
    end else begin
      if (accept) begin
        word <= Data;
        Busy <= 1'b1;
        Mismatch <= 1'b0;
      end else if (state == DONE) Busy <= 1'b0;
      Done <= state == DONE;
      LatchEn <= state == PULSE;
      if (state == SETUP) LatchD <= word;
      if (state == READ) begin
        ReadData <= LatchQ;
        Mismatch <= LatchQ != word;
      end
    end
  end
endmodule

// File: tb/tb_latch_bank_writer.sv
// tb_latch_bank_writer: directed checks of latch_bank_writer against a behavioural latch bank
module tb_latch_bank_writer;
  logic Clk = 0, Reset = 1, Start = 0;
  logic [7:0] Data = 0, stuck = 0;
  logic Busy, Done, Mismatch, LatchEn;
  logic [7:0] ReadData, LatchD, LatchQ, lq;
  logic a_start = 0;
  logic [7:0] a_data = 0;
  logic a_busy, a_done, a_mis, a_en;
  logic [7:0] a_rd, a_d, a_q, a_lq;
`ifdef LATCH_BANK_WRITER_RETRY_EN
  logic Retried, a_retried;
`endif
  int checks = 0, failures = 0;
  int t_lat, t_en, t_rise, t_first, t_bad;
  always #5 Clk = ~Clk;
  latch_bank_writer u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Data(Data), .Busy(Busy), .Done(Done),
    .Mismatch(Mismatch), .ReadData(ReadData), .LatchD(LatchD), .LatchEn(LatchEn),
`ifdef LATCH_BANK_WRITER_RETRY_EN
    .Retried(Retried),
`endif
    .LatchQ(LatchQ)
  );
  latch_bank_writer #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) u_alt (
    .Clk(Clk), .Reset(Reset), .Start(a_start), .Data(a_data), .Busy(a_busy), .Done(a_done),
    .Mismatch(a_mis), .ReadData(a_rd), .LatchD(a_d), .LatchEn(a_en),
`ifdef LATCH_BANK_WRITER_RETRY_EN
    .Retried(a_retried),
`endif
    .LatchQ(a_q)
  );
  always_latch if (LatchEn) lq <= LatchD;
  always_latch if (a_en) a_lq <= a_d;
  assign LatchQ = lq & ~stuck;
  assign a_q = a_lq;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Call just after a negedge; k counts edges after the Start-accept edge.
  task automatic txn(input logic [7:0] d, input logic [7:0] d2);
    logic prev;
    Data = d;
    Start = 1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 0;
    Data = d2;
    t_lat = -1; t_en = 0; t_rise = 0; t_first = -1; t_bad = 0; prev = 0;
    check("busy_after_accept", Busy, 1);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge Clk);
      if (LatchEn) begin
        t_en++;
        if (t_first < 0) t_first = k;
        if (!prev) t_rise++;
      end
      prev = LatchEn;
      if (k >= 1 && LatchD !== d) t_bad++;
      if (Done) begin t_lat = k; break; end
    end
    check("busy_at_done", Busy, 0);
    @(negedge Clk);
    check("done_one_cycle", Done, 0);
    @(negedge Clk);
  endtask
  initial begin
    logic pb, pd, pe;
    int n_acc, n_done, n_en, lat;
    repeat (3) @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_mismatch", Mismatch, 0);
    check("rst_readdata", ReadData, 0);
    check("rst_latchd", LatchD, 0);
    check("rst_latchen", LatchEn, 0);
    Reset = 0;
    @(negedge Clk);
    txn(8'hA5, 8'hA5);
    check("a5_latency", t_lat, 6);
    check("a5_en_cycles", t_en, 2);
    check("a5_en_start", t_first, 2);
    check("a5_latchd_stable", t_bad, 0);
    check("a5_readdata", ReadData, 8'hA5);
    check("a5_mismatch", Mismatch, 0);
    check("a5_latchd_idle", LatchD, 8'hA5);
    stuck = 8'h08;
    txn(8'hFF, 8'hFF);
    check("stuck_readdata", ReadData, 8'hF7);
    check("stuck_mismatch", Mismatch, 1);
`ifdef LATCH_BANK_WRITER_RETRY_EN
    check("stuck_latency", t_lat, 11);
    check("stuck_pulses", t_rise, 2);
    check("stuck_en_cycles", t_en, 4);
    check("stuck_retried", Retried, 1);
`else
    check("stuck_latency", t_lat, 6);
    check("stuck_pulses", t_rise, 1);
`endif
    stuck = 8'h00;
    txn(8'h3C, 8'hC3);
    check("chg_latchd_stable", t_bad, 0);
    check("chg_readdata", ReadData, 8'h3C);
    check("chg_mismatch", Mismatch, 0);
    check("chg_latency", t_lat, 6);
`ifdef LATCH_BANK_WRITER_RETRY_EN
    check("clean_retried", Retried, 0);
`endif
    Data = 8'h11;
    Start = 1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 0;
    for (int k = 0; k < 10 && !LatchEn; k++) @(negedge Clk);
    check("pulse_reached", LatchEn, 1);
    Reset = 1;
    @(posedge Clk);
    #1;
    check("mid_rst_latchen", LatchEn, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_latchd", LatchD, 0);
    check("mid_rst_readdata", ReadData, 0);
    check("mid_rst_mismatch", Mismatch, 0);
    @(negedge Clk);
    Reset = 0;
    n_done = 0;
    repeat (12) begin
      @(negedge Clk);
      if (Done) n_done++;
    end
    check("mid_rst_no_done", n_done, 0);
    txn(8'h5A, 8'h5A);
    check("post_rst_latency", t_lat, 6);
    check("post_rst_readdata", ReadData, 8'h5A);
    Data = 8'h66;
    Start = 1;
    n_acc = 0; n_done = 0; n_en = 0;
    pb = Busy; pd = Done; pe = LatchEn;
    for (int i = 0; i < 35; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (i == 19) Start = 0;
      if (Busy && !pb) n_acc++;
      if (Done && !pd) n_done++;
      if (LatchEn && !pe) n_en++;
      pb = Busy; pd = Done; pe = LatchEn;
    end
    check("b2b_accepts", n_acc, 3);
    check("b2b_dones", n_done, 3);
    check("b2b_pulses", n_en, 3);
    check("b2b_idle", Busy, 0);
    a_data = 8'h9E;
    a_start = 1;
    @(posedge Clk);
    @(negedge Clk);
    a_start = 0;
    lat = -1; n_en = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge Clk);
      if (a_en) n_en++;
      if (a_done) begin lat = k; break; end
    end
    check("alt_latency", lat, 10);
    check("alt_en_cycles", n_en, 1);
    check("alt_readdata", a_rd, 8'h9E);
    check("alt_mismatch", a_mis, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
